bm_sevenseg_sink: RTL and testbench



---
 rtl/bm_sevenseg_pkg.sv | 36 +++
 rtl/bm_sevenseg_sink_hex7seg.sv | 32 +++
 rtl/bm_sevenseg_sink.sv | 126 ++++++++++++
 tb/tb_bm_sevenseg_sink.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bm_sevenseg_pkg.sv
// Shared constants for the BondMachine seven-segment sink: hex segment
// patterns (active-high, seg[0]=a .. seg[6]=g) and display geometry.
package bm_sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] digit_idx_t;

  // One-hot active-high anode enable for a digit slot.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bm_sevenseg_sink_hex7seg.sv
// Combinational nibble to active-high seven-segment pattern decoder.
module bm_hex7seg
  import bm_sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bm_sevenseg_sink.sv
// Consumes BondMachine o0 words over the valid/received handshake and shows
// them on the Basys3 4-digit multiplexed display and the 16 LEDs.
module bm_sevenseg_sink
  import bm_sevenseg_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter int FLASH_BITS   = 24,
  parameter int ACTIVE_LOW   = 1,
  parameter int BLANK_LZ     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i0,
  input  logic        i0_valid,
  output logic        i0_received,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] led
);

  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [FLASH_BITS-1:0] FLASH_LOAD = {FLASH_BITS{1'b1}};

  logic [15:0]             value_q, value_d;
  logic                    recv_q, recv_d;
  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  digit_idx_t              digit_q, digit_d;
  logic [FLASH_BITS-1:0]   flash_q, flash_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic       capture;
  logic       wrap;
  logic [3:0] nibble;
  logic [6:0] hex_seg;
  logic       lead_zero;

  bm_hex7seg u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // A word is taken only when no ack is outstanding, so a held valid
  // produces alternating captures rather than a stuck ack.
  always_comb begin
    capture = i0_valid & ~recv_q;
    wrap    = (presc_q == {REFRESH_BITS{1'b1}});

    value_d = capture ? i0 : value_q;
    recv_d  = capture;
    presc_d = presc_q + 1'b1;
    digit_d = wrap ? digit_idx_t'(digit_q + 2'd1) : digit_q;

    flash_d = flash_q;
    if (capture)
      flash_d = FLASH_LOAD;
    else if (flash_q != '0)
      flash_d = flash_q - 1'b1;
  end

  always_comb begin
    nibble    = value_q[3:0];
    lead_zero = 1'b0;
    case (digit_q)
      2'd0: begin
        nibble    = value_q[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        nibble    = value_q[7:4];
        lead_zero = (value_q[15:4] == '0);
      end
      2'd2: begin
        nibble    = value_q[11:8];
        lead_zero = (value_q[15:8] == '0);
      end
      2'd3: begin
        nibble    = value_q[15:12];
        lead_zero = (value_q[15:12] == '0);
      end
      default: begin
        nibble    = value_q[3:0];
        lead_zero = 1'b0;
      end
    endcase
  end

  // Pin polarity is folded in here so everything upstream stays active-high.
  always_comb begin
    an_d  = digit_onehot(digit_q) ^ {4{POL}};
    seg_d = ((BLANK_LZ != 0) && lead_zero) ? (SEG_BLANK ^ {7{POL}})
                                           : (hex_seg ^ {7{POL}});
    dp_d  = ((flash_q != '0) && (digit_q == 2'd0)) ^ POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      recv_q  <= 1'b0;
      presc_q <= '0;
      digit_q <= '0;
      flash_q <= '0;
      an_q    <= {4{POL}};
      seg_q   <= {7{POL}};
      dp_q    <= POL;
    end else begin
      value_q <= value_d;
      recv_q  <= recv_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      flash_q <= flash_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign i0_received = recv_q;
  assign led         = value_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;

endmodule

// File: tb/tb_bm_sevenseg_sink.sv
// Bench for bm_sevenseg_sink: captured words are queued and checked by a
// monitor on each ack pulse; display scan is checked against a small model.
module tb_bm_sevenseg_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i0;
  logic        i0_valid;

  logic        recv_a, dp_a, recv_b, dp_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;
  logic [15:0] led_a, led_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cap_cyc = -100;
  logic [15:0] disp_val = '0;
  logic [15:0] exp_q[$];
  logic prev_recv = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  bm_sevenseg_sink #(.REFRESH_BITS(2), .FLASH_BITS(3), .ACTIVE_LOW(1), .BLANK_LZ(0)) dut_a (
    .clk(clk), .reset(reset), .i0(i0), .i0_valid(i0_valid), .i0_received(recv_a),
    .seg(seg_a), .dp(dp_a), .an(an_a), .led(led_a));

  bm_sevenseg_sink #(.REFRESH_BITS(2), .FLASH_BITS(3), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .i0(i0), .i0_valid(i0_valid), .i0_received(recv_b),
    .seg(seg_b), .dp(dp_b), .an(an_b), .led(led_b));

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Scoreboard monitor: every ack must carry the next queued word.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (recv_a === 1'b1) begin
      n_vec++;
      if (prev_recv) begin
        n_err++;
        $display("FAIL recv_consecutive: got two adjacent received cycles at cyc %0d", cyc);
      end
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL led_unexpected: got received with led=%h, none expected", led_a);
      end else begin
        exp_w = exp_q.pop_front();
        if (led_a !== exp_w) begin
          n_err++;
          $display("FAIL led_capture: got %h, expected %h", led_a, exp_w);
        end
      end
    end
    prev_recv = (recv_a === 1'b1);
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Display model: output after edge cyc reflects the digit slot before that edge.
  task automatic check_disp(input int n);
    int d;
    int age;
    logic [3:0] nib;
    logic [6:0] exp_b;
    logic lit;
    repeat (n) begin
      step();
      d   = ((cyc - 1) >> 2) & 3;
      nib = 4'((disp_val >> (4 * d)) & 16'hF);
      age = cyc - cap_cyc;
      lit = (age >= 1) && (age <= 7) && (d == 0);
      chk("an_scan", {12'h0, an_a}, {12'h0, ~(4'b0001 << d)});
      chk("seg_scan", {9'h0, seg_a}, {9'h0, ~hex_tab[nib]});
      chk("dp_flash", {15'h0, dp_a}, {15'h0, ~lit});
      if ((d > 0) && ((disp_val >> (4 * d)) == 0)) exp_b = 7'h7F;
      else                                          exp_b = ~hex_tab[nib];
      chk("seg_blank_lz", {9'h0, seg_b}, {9'h0, exp_b});
    end
  endtask

  task automatic capture(input logic [15:0] val);
    i0 = val;
    i0_valid = 1'b1;
    exp_q.push_back(val);
    step();
    i0_valid = 1'b0;
    cap_cyc = cyc;
    disp_val = val;
  endtask

  // Advance until the next edge lands on slot r of the 16-cycle scan.
  task automatic align(input int r);
    for (int k = 0; k < 16 && ((cyc + 1) % 16) != r; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i0 = '0;
    i0_valid = 1'b0;
    repeat (3) begin
      step();
      chk("rst_an", {12'h0, an_a}, 16'h000F);
      chk("rst_seg", {9'h0, seg_a}, 16'h007F);
      chk("rst_dp", {15'h0, dp_a}, 16'h0001);
      chk("rst_led", led_a, 16'h0000);
      chk("rst_recv", {15'h0, recv_a}, 16'h0000);
    end
    reset = 1'b0;
    step();
    chk("first_an", {12'h0, an_a}, 16'h000E);
    chk("first_seg", {9'h0, seg_a}, 16'h0040);
    check_disp(3);

    align(0);
    capture(16'hA5C3);
    check_disp(1);
    chk("recv_one_cycle", {15'h0, recv_a}, 16'h0000);
    check_disp(16);

    i0 = 16'h0001;
    i0_valid = 1'b1;
    repeat (3) exp_q.push_back(16'h0001);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("held_valid_recv", {15'h0, recv_a}, (i % 2 == 0) ? 16'h1 : 16'h0);
      if (i == 4) cap_cyc = cyc;
    end
    i0_valid = 1'b0;
    disp_val = 16'h0001;
    check_disp(4);

    align(8);
    capture(16'h1234);
    check_disp(3);
    capture(16'h5678);
    check_disp(12);

    capture(16'h0040);
    check_disp(16);
    capture(16'h0000);
    check_disp(16);

    i0 = 16'hBEEF;
    i0_valid = 1'b1;
    exp_q.push_back(16'hBEEF);
    step();
    reset = 1'b1;
    i0_valid = 1'b0;
    step();
    chk("midrst_recv", {15'h0, recv_a}, 16'h0000);
    chk("midrst_led", led_a, 16'h0000);
    chk("midrst_an", {12'h0, an_a}, 16'h000F);
    chk("midrst_seg", {9'h0, seg_a}, 16'h007F);
    reset = 1'b0;
    cap_cyc = -100;
    disp_val = '0;
    check_disp(2);
    capture(16'h0F0F);
    check_disp(8);

    repeat (2) step();
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
